// File: rtl/core_pkg.sv
// Shared core definitions: datapath width, branch funct3 encodings, writeback select encodings.
package core_pkg;

   localparam int XLEN = 32;

   typedef enum logic [2:0] {
      F3_BEQ  = 3'b000,
      F3_BNE  = 3'b001,
      F3_BLT  = 3'b100,
      F3_BGE  = 3'b101,
      F3_BLTU = 3'b110,
      F3_BGEU = 3'b111
   } br_f3_e;

   typedef enum logic [1:0] {
      RES_ALU = 2'b00,
      RES_MEM = 2'b01,
      RES_PC4 = 2'b10
   } result_src_e;

endpackage

// File: rtl/branch_cond.sv
// Branch condition evaluation from ALU flags; purely combinational, no flow control.
// Unsigned less-than is derived from a local 33-bit subtract rather than the ALU carry.
module branch_cond
   import core_pkg::*;
#(
   parameter int W = XLEN
) (
   input  logic [2:0]   funct3,
   input  logic         zero,
   input  logic         negative,
   input  logic         overflow,
   input  logic [W-1:0] src_a,
   input  logic [W-1:0] src_b,
   output logic         cond
);

   logic [W:0] diff;
   logic       ltu;
   logic       lt;
   logic       unused_diff_lo;

   assign diff           = {1'b0, src_a} - {1'b0, src_b};
   assign ltu            = diff[W];
   assign lt             = negative ^ overflow;
   // Only the borrow out of the subtract carries meaning here.
   assign unused_diff_lo = ^diff[W-1:0];

   always_comb begin
      cond = 1'b0;
      case (funct3)
         F3_BEQ:  cond = zero;
         F3_BNE:  cond = ~zero;
         F3_BLT:  cond = lt;
         F3_BGE:  cond = ~lt;
         F3_BLTU: cond = ltu;
         F3_BGEU: cond = ~ltu;
         default: cond = 1'b0;
      endcase
   end

endmodule

// File: rtl/ex_mem_stage.sv
// EX branch/jump redirect (same cycle) and EX/MEM register (1 clk); StallM holds MEM, FlushM bubbles it.
// Redirect counter keeps running under StallM because EX itself is not stalled by it.
module ex_mem_stage
   import core_pkg::*;
#(
   parameter int XLEN  = core_pkg::XLEN,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ValidE,
   input  logic [XLEN-1:0]  ALUResultE,
   input  logic             ZeroE,
   input  logic             NegativeE,
   input  logic             OverFlowE,
   input  logic [XLEN-1:0]  SrcAE,
   input  logic [XLEN-1:0]  SrcBE,
   input  logic [XLEN-1:0]  WriteDataE,
   input  logic [4:0]       RdE,
   input  logic [XLEN-1:0]  PCPlus4E,
   input  logic [XLEN-1:0]  PCTargetE,
   input  logic [2:0]       funct3E,
   input  logic             BranchE,
   input  logic             JumpE,
   input  logic             RegWriteE,
   input  logic             MemWriteE,
   input  logic [1:0]       ResultSrcE,
   input  logic             StallM,
   input  logic             FlushM,
   output logic             PCSrcE,
   output logic             MisalignE,
   output logic             ValidM,
   output logic             RegWriteM,
   output logic             MemWriteM,
   output logic [1:0]       ResultSrcM,
   output logic [XLEN-1:0]  ALUResultM,
   output logic [XLEN-1:0]  WriteDataM,
   output logic [XLEN-1:0]  PCPlus4M,
   output logic [4:0]       RdM,
   output logic             MisalignM,
   output logic [CNT_W-1:0] TakenCnt
);

   logic            cond;
   logic            take;
   logic            unused_tgt_hi;

   logic            valid_d, valid_q;
   logic            reg_write_d, reg_write_q;
   logic            mem_write_d, mem_write_q;
   logic            misalign_d, misalign_q;
   logic [1:0]      result_src_d, result_src_q;
   logic [XLEN-1:0] alu_result_d, alu_result_q;
   logic [XLEN-1:0] write_data_d, write_data_q;
   logic [XLEN-1:0] pc_plus4_d, pc_plus4_q;
   logic [4:0]      rd_d, rd_q;
   logic [CNT_W-1:0] cnt_d, cnt_q;

   branch_cond #(.W(XLEN)) u_branch_cond (
      .funct3   (funct3E),
      .zero     (ZeroE),
      .negative (NegativeE),
      .overflow (OverFlowE),
      .src_a    (SrcAE),
      .src_b    (SrcBE),
      .cond     (cond)
   );

   assign take      = ValidE & (JumpE | (BranchE & cond));
   assign MisalignE = take & (PCTargetE[1:0] != 2'b00);
   assign PCSrcE    = take & ~MisalignE;
   // The full target goes straight to fetch; only the low bits are inspected here.
   assign unused_tgt_hi = ^PCTargetE[XLEN-1:2];

   always_comb begin
      valid_d      = valid_q;
      reg_write_d  = reg_write_q;
      mem_write_d  = mem_write_q;
      misalign_d   = misalign_q;
      result_src_d = result_src_q;
      alu_result_d = alu_result_q;
      write_data_d = write_data_q;
      pc_plus4_d   = pc_plus4_q;
      rd_d         = rd_q;

      if (FlushM) begin
         valid_d      = 1'b0;
         reg_write_d  = 1'b0;
         mem_write_d  = 1'b0;
         misalign_d   = 1'b0;
         result_src_d = 2'b00;
         alu_result_d = '0;
         write_data_d = '0;
         pc_plus4_d   = '0;
         rd_d         = '0;
      end else if (!StallM) begin
         valid_d      = ValidE & ~MisalignE;
         reg_write_d  = RegWriteE & ValidE & ~MisalignE;
         mem_write_d  = MemWriteE & ValidE & ~MisalignE;
         misalign_d   = MisalignE;
         result_src_d = ResultSrcE;
         alu_result_d = ALUResultE;
         write_data_d = WriteDataE;
         pc_plus4_d   = PCPlus4E;
         rd_d         = RdE;
      end

      cnt_d = cnt_q;
      if (PCSrcE && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         valid_q      <= 1'b0;
         reg_write_q  <= 1'b0;
         mem_write_q  <= 1'b0;
         misalign_q   <= 1'b0;
         result_src_q <= 2'b00;
         alu_result_q <= '0;
         write_data_q <= '0;
         pc_plus4_q   <= '0;
         rd_q         <= '0;
         cnt_q        <= '0;
      end else begin
         valid_q      <= valid_d;
         reg_write_q  <= reg_write_d;
         mem_write_q  <= mem_write_d;
         misalign_q   <= misalign_d;
         result_src_q <= result_src_d;
         alu_result_q <= alu_result_d;
         write_data_q <= write_data_d;
         pc_plus4_q   <= pc_plus4_d;
         rd_q         <= rd_d;
         cnt_q        <= cnt_d;
      end
   end

   assign ValidM     = valid_q;
   assign RegWriteM  = reg_write_q;
   assign MemWriteM  = mem_write_q;
   assign MisalignM  = misalign_q;
   assign ResultSrcM = result_src_q;
   assign ALUResultM = alu_result_q;
   assign WriteDataM = write_data_q;
   assign PCPlus4M   = pc_plus4_q;
   assign RdM        = rd_q;
   assign TakenCnt   = cnt_q;

endmodule
